sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Parametrised K×K sliding-window generator feeding the Sobel/convolution datapath from a raster pixel stream. It replaces fixed 3×3 line buffering with compile-time window size, pixel width and maximum line length. Image width and height are set per frame at run time. It adds ready/valid backpressure on both sides, a frame-done pulse and configuration error detection. It sits between the pixel input port and the kernel multiply/threshold stage inside the Sobel top level.

## Interface
- DATA_W, 8, pixel width in bits
- K, 3, window size (odd, 3..7)
- MAX_WIDTH, 1024, maximum line length; sizes K-1 line memories of MAX_WIDTH×DATA_W
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  latch cfg_width/cfg_height and begin a frame (honoured only in IDLE)
- cfg_width  in  16  image width in pixels
- cfg_height  in  16  image height in lines
- pixel_in  in  DATA_W  raster pixel, row-major
- valid_in  in  1  pixel_in valid
- in_ready  out  1  block accepts pixel this cycle
- win_data  out  K*K*DATA_W  window; element (i,j) at bits [(i*K+j)*DATA_W +: DATA_W], i=0 top (oldest) row, j=0 leftmost column
- win_valid  out  1  win_data valid
- out_ready  in  1  downstream accepts window
- busy  out  1  state is RUN or DRAIN
- frame_done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  sticky configuration error

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. start=1 with K ≤ cfg_width ≤ MAX_WIDTH and cfg_height ≥ K latches both values, clears x/y counters and cfg_err, and enters RUN. An invalid config sets cfg_err and stays in IDLE.
- Accept condition: state==RUN && valid_in && in_ready. valid_in outside RUN is ignored.
- in_ready = (state==RUN) && (!win_valid || out_ready). This is a single output register; there is no skid buffer.
- On accept at column x, row y:
  - Shift the K-column window register left by one column.
  - The new right column is formed from the K-1 line memories at address x (oldest on top) plus pixel_in at the bottom.
  - Write pixel_in into the newest line memory at address x and shift the line chain up.
  - Advance x; at x==width-1, wrap x to 0 and increment y.
- Window emission: the accept at x ≥ K-1 and y ≥ K-1 registers win_data and sets win_valid. The window is centred at (x-(K-1)/2, y-(K-1)/2). Outputs are valid-only; there is no border padding.
  - Windows per frame = (W-K+1)·(H-K+1).
- Columns left over from the previous line never appear in an emitted window, so the window register needs no row-start clearing.
- win_valid clears when out_ready=1 and no new window is loaded the same cycle. A load plus a handshake in the same cycle keeps win_valid=1 with the new data.
- The accept of the last pixel (x=W-1, y=H-1) moves the FSM to DRAIN. In DRAIN, in_ready=0.
- DRAIN: when win_valid is 0, or becomes 0 via a handshake, pulse frame_done for one cycle and go to IDLE.
- start in RUN or DRAIN is ignored. cfg_width/cfg_height changes after start have no effect.
- Arithmetic: x and y are 16 bits. Pixel data passes through unmodified; there are no arithmetic width changes.

## Timing
- Reset values: in_ready=0, win_valid=0, win_data=0, busy=0, frame_done=0, cfg_err=0, state=IDLE, x=y=0. Line memory contents are don't-care.
- start is sampled on edge n. busy=1 and in_ready=1 follow from edge n+1 (when out_ready permits).
- Latency: the window becomes visible the cycle after its triggering accept (1 cycle).
- Throughput: 1 pixel/cycle while out_ready=1.
- frame_done fires in the cycle after the final window handshake. If that window is consumed in the same cycle it is produced, frame_done fires no earlier than one cycle after the last accept.
- Asserting reset_n low mid-frame immediately returns the block to IDLE with all outputs at their reset values. The partial frame is discarded.
- The line memory read must be combinational or same-cycle: no bubble at row wrap.

## Test plan
- K=3, DATA_W=8, MAX_WIDTH=16; start with 5×4; stream 1..20 with out_ready=1 → exactly 6 windows.
  - First window {1,2,3,6,7,8,11,12,13} one cycle after pixel 13 is accepted.
  - Last window {8,9,10,13,14,15,18,19,20}.
  - frame_done pulses once, then busy=0.
- Same frame with out_ready toggling 1,0,0,1… → in_ready=0 whenever win_valid && !out_ready. The window sequence is unchanged, with no drops and no duplicates.
- Invalid configs width=2, then width=17, then height=1 → cfg_err=1, busy stays 0, in_ready stays 0. A following valid 5×4 start clears cfg_err.
- K=5 instance, 6×6 image with pixels 0..35 → 4 windows. The first is rows 0–4 × cols 0–4, with element (4,4)=28.
- Assert reset_n low after 12 pixels, release, then run a new 5×4 frame → all outputs at reset values during reset; the new frame's windows are correct and carry no data from the aborted frame.
- start held high during RUN, and valid_in=1 in IDLE → both ignored: counters unchanged, and no win_valid produced from IDLE.

Source files
------------

// File: rtl/sobel_window_gen.sv
// K x K sliding-window generator over a raster pixel stream.
// K-1 line memories feed the right column; valid-only windows, no padding.
module sobel_window_gen #(
   parameter int DATA_W    = 8,
   parameter int K         = 3,
   parameter int MAX_WIDTH = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [15:0]             cfg_width,
   input  logic [15:0]             cfg_height,
   input  logic [DATA_W-1:0]       pixel_in,
   input  logic                    valid_in,
   output logic                    in_ready,
   output logic [K*K*DATA_W-1:0]   win_data,
   output logic                    win_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    cfg_err
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [15:0] K16  = 16'(K);
   localparam logic [15:0] EDGE = 16'(K - 1);
   localparam logic [16:0] MAXW = 17'(MAX_WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nx;

   logic [15:0]       width, height, x, y;
   logic [DATA_W-1:0] lm  [K-1][MAX_WIDTH];
   logic [DATA_W-1:0] win [K][K];
   logic [DATA_W-1:0] col [K];
   logic [AW-1:0]     addr;
   logic              cfg_ok, accept, load;
   logic              x_last, y_last, done_nx;

   assign cfg_ok = (cfg_width >= K16) &&
                   ({1'b0, cfg_width} <= MAXW) &&
                   (cfg_height >= K16);

   assign in_ready = (state == RUN) && (!win_valid || out_ready);
   assign accept   = valid_in && in_ready;
   assign x_last   = (x == width - 16'd1);
   assign y_last   = (y == height - 16'd1);
   assign load     = accept && (x >= EDGE) && (y >= EDGE);
   assign busy     = (state != IDLE);
   assign addr     = x[AW-1:0];

   // Read is combinational so a row wrap costs no bubble.
   always_comb begin
      for (int i = 0; i < K - 1; i++) begin
         col[i] = lm[i][addr];
      end
      col[K-1] = pixel_in;
   end

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && cfg_ok) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (accept && x_last && y_last) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (!win_valid || out_ready) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         width      <= '0;
         height     <= '0;
         x          <= '0;
         y          <= '0;
         cfg_err    <= 1'b0;
         frame_done <= 1'b0;
         win_valid  <= 1'b0;
      end else begin
         frame_done <= done_nx;
         if (state == IDLE && start) begin
            if (cfg_ok) begin
               width   <= cfg_width;
               height  <= cfg_height;
               x       <= '0;
               y       <= '0;
               cfg_err <= 1'b0;
            end else begin
               cfg_err <= 1'b1;
            end
         end
         if (accept) begin
            if (x_last) begin
               x <= '0;
               y <= y + 16'd1;
            end else begin
               x <= x + 16'd1;
            end
         end
         if (load) begin
            win_valid <= 1'b1;
         end else if (out_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

   // Stale columns from the previous row are shifted out before any emit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               win[i][j] <= '0;
            end
         end
      end else if (accept) begin
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
               win[i][j] <= win[i][j+1];
            end
            win[i][K-1] <= col[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < K - 2; i++) begin
            lm[i][addr] <= lm[i+1][addr];
         end
         lm[K-2][addr] <= pixel_in;
      end
   end

   for (genvar gi = 0; gi < K; gi++) begin : g_row
      for (genvar gj = 0; gj < K; gj++) begin : g_col
         assign win_data[(gi*K+gj)*DATA_W +: DATA_W] = win[gi][gj];
      end
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: K=3 and K=5 instances against an
// image-level window model (expected windows cut straight from the frame).
module tb_sobel_window_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        start, valid_in, out_ready;
   logic [15:0] cfg_width, cfg_height;
   logic [7:0]  pixel_in;
   logic        in_ready, win_valid, busy, frame_done, cfg_err;
   logic [71:0] win_data;

   logic        f_start, f_valid, f_oready;
   logic [15:0] f_w, f_h;
   logic [7:0]  f_pix;
   logic        f_iready, f_wvalid, f_busy, f_done, f_err;
   logic [199:0] f_win;

   int checks = 0;
   int errors = 0;
   logic [199:0] exp_q [$];

   sobel_window_gen #(.DATA_W(8), .K(3), .MAX_WIDTH(16)) u3 (
      .clk(clk), .reset_n(reset_n), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .pixel_in(pixel_in), .valid_in(valid_in), .in_ready(in_ready),
      .win_data(win_data), .win_valid(win_valid), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
   );

   sobel_window_gen #(.DATA_W(8), .K(5), .MAX_WIDTH(16)) u5 (
      .clk(clk), .reset_n(reset_n), .start(f_start),
      .cfg_width(f_w), .cfg_height(f_h),
      .pixel_in(f_pix), .valid_in(f_valid), .in_ready(f_iready),
      .win_data(f_win), .win_valid(f_wvalid), .out_ready(f_oready),
      .busy(f_busy), .frame_done(f_done), .cfg_err(f_err)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [199:0] obs,
                       input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int base, input int w,
                                      input int r, input int c);
      return 8'(base + r * w + c);
   endfunction

   // rmode: 0 always ready, 1 pattern 1,0,0, 2 random.
   task automatic run_frame(input int w, input int h, input int base,
                            input int rmode, input int vmode,
                            input int hold_start, input int abort);
      int n, nwin, idx, got, fd, cyc;
      bit trig;
      logic [199:0] v, e;
      n = w * h;
      nwin = (w - 2) * (h - 2);
      idx = 0; got = 0; fd = 0; cyc = 0; trig = 0;
      exp_q.delete();
      for (int cy = 0; cy <= h - 3; cy++) begin
         for (int cx = 0; cx <= w - 3; cx++) begin
            v = '0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  v[(i*3+j)*8 +: 8] = pix(base, w, cy + i, cx + j);
               end
            end
            exp_q.push_back(v);
         end
      end
      @(negedge clk);
      cfg_width = 16'(w);
      cfg_height = 16'(h);
      start = 1'b1;
      valid_in = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      start = (hold_start != 0);
      cfg_width = 16'($urandom_range(3, 16));
      cfg_height = 16'($urandom_range(3, 9));
      #1;
      chk1("busy_after_start", busy, 1'b1);
      chk1("cfg_err_after_start", cfg_err, 1'b0);
      chk1("in_ready_after_start", in_ready, 1'b1);
      while ((idx < n || got < nwin) && cyc < 3000 &&
             !(abort > 0 && idx >= abort)) begin
         @(negedge clk);
         cyc++;
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 1);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         valid_in = (vmode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
         pixel_in = (idx < n) ? pix(base, w, idx / w, idx % w)
                              : 8'($urandom);
         #1;
         if (frame_done) fd++;
         if (trig) chk1("win_latency", win_valid, 1'b1);
         trig = 0;
         if (win_valid && !out_ready) chk1("in_ready_bp", in_ready, 1'b0);
         if (idx >= n) chk1("in_ready_drain", in_ready, 1'b0);
         if (win_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk1("extra_window", win_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chkw("window", 200'(win_data), e);
               got++;
            end
         end
         if (in_ready && valid_in && idx < n) begin
            if (idx % w >= 2 && idx / w >= 2) trig = 1;
            idx++;
         end
      end
      if (abort > 0) return;
      checks++;
      assert (cyc < 3000) else begin
         errors++;
         $error("FAIL frame_timeout observed=%0d expected<3000", cyc);
      end
      repeat (6) begin
         @(negedge clk);
         out_ready = 1'b1;
         valid_in = 1'b0;
         start = 1'b0;
         #1;
         if (frame_done) fd++;
      end
      chki("frame_done_count", fd, 1);
      chki("windows", got, nwin);
      chki("leftover", exp_q.size(), 0);
      chk1("busy_end", busy, 1'b0);
      chk1("win_valid_end", win_valid, 1'b0);
      chk1("in_ready_end", in_ready, 1'b0);
   endtask

   task automatic bad_cfg(input int w, input int h);
      @(negedge clk);
      cfg_width = 16'(w);
      cfg_height = 16'(h);
      start = 1'b1;
      valid_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("cfg_err_set", cfg_err, 1'b1);
      chk1("busy_bad", busy, 1'b0);
      chk1("in_ready_bad", in_ready, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk1("busy_bad_hold", busy, 1'b0);
      chk1("in_ready_bad_hold", in_ready, 1'b0);
      valid_in = 1'b0;
   endtask

   initial begin
      int idx, got, cyc, fd;
      logic [199:0] q5 [$];
      logic [199:0] v;

      reset_n = 1'b0;
      start = 0; valid_in = 0; out_ready = 1;
      cfg_width = 0; cfg_height = 0; pixel_in = 0;
      f_start = 0; f_valid = 0; f_oready = 1;
      f_w = 0; f_h = 0; f_pix = 0;
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_win_valid", win_valid, 1'b0);
      chkw("rst_win_data", 200'(win_data), '0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk1("rst_cfg_err", cfg_err, 1'b0);
      chkw("rst_k5_win", f_win, '0);
      @(negedge clk);
      reset_n = 1'b1;

      // valid_in while idle must be ignored
      repeat (5) begin
         @(negedge clk);
         valid_in = 1'b1;
         pixel_in = 8'($urandom);
         #1;
         chk1("idle_in_ready", in_ready, 1'b0);
         chk1("idle_win_valid", win_valid, 1'b0);
      end
      valid_in = 1'b0;

      run_frame(5, 4, 1, 0, 0, 0, 0);
      run_frame(5, 4, 1, 1, 0, 0, 0);

      bad_cfg(2, 4);
      bad_cfg(17, 4);
      bad_cfg(5, 1);
      run_frame(5, 4, 1, 0, 0, 1, 0);

      // K=5, 6x6, pixels 0..35
      for (int cy = 0; cy < 2; cy++) begin
         for (int cx = 0; cx < 2; cx++) begin
            v = '0;
            for (int i = 0; i < 5; i++) begin
               for (int j = 0; j < 5; j++) begin
                  v[(i*5+j)*8 +: 8] = 8'((cy + i) * 6 + cx + j);
               end
            end
            q5.push_back(v);
         end
      end
      @(negedge clk);
      f_w = 16'd6; f_h = 16'd6; f_start = 1'b1; f_oready = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      idx = 0; got = 0; cyc = 0; fd = 0;
      while (got < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         f_valid = (idx < 36);
         f_pix = 8'(idx);
         #1;
         if (f_done) fd++;
         if (f_wvalid) begin
            if (q5.size() == 0) begin
               chk1("k5_extra", f_wvalid, 1'b0);
            end else begin
               chkw("k5_window", f_win, q5.pop_front());
            end
            if (got == 0) chki("k5_elem44", int'(f_win[(4*5+4)*8 +: 8]), 28);
            got++;
         end
         if (f_iready && f_valid) idx++;
      end
      f_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (f_done) fd++;
         chk1("k5_no_more", f_wvalid, 1'b0);
      end
      chki("k5_windows", got, 4);
      chki("k5_frame_done", fd, 1);
      chk1("k5_busy_end", f_busy, 1'b0);

      // reset mid-frame, then a clean frame
      run_frame(5, 4, 100, 0, 0, 0, 12);
      @(negedge clk);
      reset_n = 1'b0;
      valid_in = 1'b0;
      #1;
      chk1("mid_rst_in_ready", in_ready, 1'b0);
      chk1("mid_rst_win_valid", win_valid, 1'b0);
      chkw("mid_rst_win_data", 200'(win_data), '0);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_frame_done", frame_done, 1'b0);
      chk1("mid_rst_cfg_err", cfg_err, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run_frame(5, 4, 200, 0, 0, 0, 0);

      run_frame(3, 3, 7, 0, 0, 0, 0);
      run_frame(16, 3, 50, 1, 1, 0, 0);
      for (int t = 0; t < 4; t++) begin
         run_frame($urandom_range(3, 16), $urandom_range(3, 7),
                   $urandom_range(0, 255), 2, 1, t % 2, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
